// File: rtl/joy_serial_pkg.sv
// rtl/joy_serial_pkg.sv - shared types, constants and helpers for the serial joystick reader
package joy_serial_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  localparam int LOAD_TICKS = 2;

  // Returns one bit per player slice (up to 4): set when that slice differs between a and b.
  function automatic logic [3:0] slice_diff(input logic [63:0] a, input logic [63:0] b,
                                            input int players, input int bits);
    logic [63:0] x;
    logic [63:0] m;
    logic [3:0]  d;
    d = '0;
    x = a ^ b;
    m = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
    for (int p = 0; p < 4; p++) begin
      if (p < players && ((x >> (p * bits)) & m) != 64'd0) d[p] = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/joy_serial_reader_if.sv
// rtl/joy_serial_reader_if.sv - serial chain signals between reader and 74HC165-style adapter
interface joy_serial_reader_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (output joy_clk, output joy_load, input joy_data);
  modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_tick_gen.sv
// rtl/joy_tick_gen.sv - shift tick divider, one-cycle tick every CLK_DIV clk_sys cycles
module joy_tick_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic hold,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !hold && (cnt == CW'(CLK_DIV - 1));
endmodule

// File: rtl/joy_serial_reader.sv
// rtl/joy_serial_reader.sv - scans PLAYERS x BITS buttons from a serial chain, debounces frames
module joy_serial_reader
  import joy_serial_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int PLAYERS    = 2,
  parameter int BITS       = 12,
  parameter int DEBOUNCE   = 2,
  parameter int GAP_TICKS  = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mask,
  joy_serial_reader_if.master       chain,
  output logic [PLAYERS*BITS-1:0]   joystick,
  output logic [PLAYERS-1:0]        changed,
  output logic                      frame_done
);
  localparam int TOTAL = PLAYERS * BITS;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int GW    = $clog2(GAP_TICKS + 1);

  state_t           state, state_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [1:0]       load_cnt, load_n;
  logic [IW-1:0]    idx, idx_n;
  logic             phase, phase_n;
  logic             joy_clk_q, joy_clk_n;
  logic             sample_en, commit, update, tick;
  logic [TOTAL-1:0] shadow, prev, raw;
  logic [2:0]       stable, stable_n;
  logic [63:0]      shadow64, raw64;
  logic [3:0]       diff;

  // The divider pauses during COMMIT so the frame period is exactly ticks*CLK_DIV + 1.
  joy_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .hold    (state == COMMIT),
    .tick    (tick)
  );

  always_comb begin
    state_n   = state;
    gap_n     = gap_cnt;
    load_n    = load_cnt;
    idx_n     = idx;
    phase_n   = phase;
    joy_clk_n = joy_clk_q;
    sample_en = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (!enable) begin
          gap_n = '0;
        end else if (tick) begin
          if (gap_cnt == GW'(GAP_TICKS - 1)) begin
            gap_n   = '0;
            load_n  = '0;
            state_n = LOAD;
          end else begin
            gap_n = gap_cnt + 1'b1;
          end
        end
      end
      LOAD: begin
        if (tick) begin
          if (load_cnt == 2'(LOAD_TICKS - 1)) begin
            idx_n   = '0;
            phase_n = 1'b0;
            state_n = SHIFT;
          end else begin
            load_n = load_cnt + 1'b1;
          end
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!phase) begin
            sample_en = 1'b1;
            joy_clk_n = 1'b1;
            phase_n   = 1'b1;
          end else begin
            joy_clk_n = 1'b0;
            phase_n   = 1'b0;
            if (idx == IW'(TOTAL - 1)) state_n = COMMIT;
            else                       idx_n   = idx + 1'b1;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    stable_n = (shadow == prev)
             ? ((stable >= 3'(DEBOUNCE)) ? 3'(DEBOUNCE) : stable + 3'd1)
             : 3'd1;
    update   = (stable_n >= 3'(DEBOUNCE)) && (shadow != raw);
    shadow64 = '0;
    raw64    = '0;
    shadow64[TOTAL-1:0] = shadow;
    raw64[TOTAL-1:0]    = raw;
    diff     = slice_diff(shadow64, raw64, PLAYERS, BITS);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      load_cnt  <= '0;
      idx       <= '0;
      phase     <= 1'b0;
      joy_clk_q <= 1'b0;
      shadow    <= '0;
      prev      <= '0;
      raw       <= '0;
      stable    <= '0;
      changed   <= '0;
      joystick  <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      load_cnt  <= load_n;
      idx       <= idx_n;
      phase     <= phase_n;
      joy_clk_q <= joy_clk_n;
      changed   <= '0;
      if (sample_en) shadow[idx] <= chain.joy_data ^ (ACTIVE_LOW != 0);
      if (commit) begin
        prev   <= shadow;
        stable <= stable_n;
        if (update) begin
          raw     <= shadow;
          changed <= diff[PLAYERS-1:0];
        end
      end
      joystick <= mask ? '0 : raw;
    end
  end

  assign chain.joy_clk  = joy_clk_q;
  assign chain.joy_load = (state != LOAD);
  assign frame_done     = (state == COMMIT);
endmodule

// File: tb/tb_joy_serial_reader.sv
// tb/tb_joy_serial_reader.sv - directed bench: 2x12 debounced, 2x12 unfiltered and 4x16 readers
module tb_joy_serial_reader;
  logic clk_sys = 1'b0;
  logic reset, enable, mask;
  logic [23:0] press_m;
  logic [63:0] press_c;

  logic [23:0] joy_m, joy_b;
  logic [63:0] joy_c;
  logic [1:0]  chg_m, chg_b;
  logic [3:0]  chg_c;
  logic        fd_m, fd_b, fd_c;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  joy_serial_reader_if u_if_m ();
  joy_serial_reader_if u_if_b ();
  joy_serial_reader_if u_if_c ();

  joy_serial_reader #(.CLK_DIV(4), .PLAYERS(2), .BITS(12), .DEBOUNCE(2), .GAP_TICKS(8), .ACTIVE_LOW(1))
    u_dut_m (.clk_sys(clk_sys), .reset(reset), .enable(enable), .mask(mask), .chain(u_if_m),
             .joystick(joy_m), .changed(chg_m), .frame_done(fd_m));
  joy_serial_reader #(.CLK_DIV(4), .PLAYERS(2), .BITS(12), .DEBOUNCE(1), .GAP_TICKS(8), .ACTIVE_LOW(1))
    u_dut_b (.clk_sys(clk_sys), .reset(reset), .enable(enable), .mask(mask), .chain(u_if_b),
             .joystick(joy_b), .changed(chg_b), .frame_done(fd_b));
  joy_serial_reader #(.CLK_DIV(4), .PLAYERS(4), .BITS(16), .DEBOUNCE(2), .GAP_TICKS(8), .ACTIVE_LOW(1))
    u_dut_c (.clk_sys(clk_sys), .reset(reset), .enable(enable), .mask(mask), .chain(u_if_c),
             .joystick(joy_c), .changed(chg_c), .frame_done(fd_c));

  // 74HC165 chain models: load resets the bit pointer, each joy_clk rise shifts by one.
  logic [7:0] ptr_m = '0, ptr_b = '0, ptr_c = '0;
  logic       pclk_m = 1'b0, pclk_b = 1'b0, pclk_c = 1'b0;

  always @(posedge clk_sys) begin
    if (!u_if_m.joy_load) ptr_m <= '0; else if (u_if_m.joy_clk && !pclk_m) ptr_m <= ptr_m + 8'd1;
    if (!u_if_b.joy_load) ptr_b <= '0; else if (u_if_b.joy_clk && !pclk_b) ptr_b <= ptr_b + 8'd1;
    if (!u_if_c.joy_load) ptr_c <= '0; else if (u_if_c.joy_clk && !pclk_c) ptr_c <= ptr_c + 8'd1;
    pclk_m <= u_if_m.joy_clk;
    pclk_b <= u_if_b.joy_clk;
    pclk_c <= u_if_c.joy_clk;
  end

  assign u_if_m.joy_data = (ptr_m < 8'd24) ? ~press_m[ptr_m[4:0]] : 1'b1;
  assign u_if_b.joy_data = (ptr_b < 8'd24) ? ~press_m[ptr_b[4:0]] : 1'b1;
  assign u_if_c.joy_data = (ptr_c < 8'd64) ? ~press_c[ptr_c[5:0]] : 1'b1;

  int   cyc = 0, last_period = 0;
  int   load_cur = 0, hi_cur = 0, rises_cur = 0;
  int   last_load = 0, last_hi = 0, last_rises = 0;
  int   chg_m_cnt = 0, chg_b_cnt = 0;
  logic [1:0] chg_m_last = '0, chg_b_last = '0;
  logic mclk_prev = 1'b0, overlap = 1'b0;

  always @(negedge clk_sys) begin
    if (fd_m) begin
      last_period <= cyc;
      cyc         <= 1;
      last_load   <= load_cur;
      last_hi     <= hi_cur;
      last_rises  <= rises_cur;
      load_cur    <= 0;
      hi_cur      <= 0;
      rises_cur   <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!u_if_m.joy_load)                load_cur  <= load_cur + 1;
      if (u_if_m.joy_clk)                  hi_cur    <= hi_cur + 1;
      if (u_if_m.joy_clk && !mclk_prev)    rises_cur <= rises_cur + 1;
    end
    mclk_prev <= u_if_m.joy_clk;
    if (u_if_m.joy_clk && !u_if_m.joy_load) overlap <= 1'b1;
    if (chg_m != 2'b00) begin chg_m_cnt <= chg_m_cnt + 1; chg_m_last <= chg_m; end
    if (chg_b != 2'b00) begin chg_b_cnt <= chg_b_cnt + 1; chg_b_last <= chg_b; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input int which, input int n);
    int seen = 0;
    int cnt  = 0;
    while (seen < n && cnt < 20000) begin
      @(negedge clk_sys);
      cnt++;
      if ((which == 0 && fd_m) || (which == 1 && fd_b) || (which == 2 && fd_c)) seen++;
    end
    if (seen < n) check("frame_timeout", 64'(seen), 64'(n));
  endtask

  task automatic wait_rises(input int n);
    int cnt = 0;
    while (rises_cur != n && cnt < 2000) begin
      @(negedge clk_sys);
      cnt++;
    end
    if (rises_cur != n) check("rise_timeout", 64'(rises_cur), 64'(n));
  endtask

  int c0, cb, n;

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    mask    = 1'b0;
    press_m = '0;
    press_c = 64'h8000_0000_0000_0000;
    repeat (5) @(negedge clk_sys);
    check("rst_joy_clk",  64'(u_if_m.joy_clk),  64'd0);
    check("rst_joy_load", 64'(u_if_m.joy_load), 64'd1);
    check("rst_joystick", 64'(joy_m),           64'd0);
    check("rst_changed",  64'(chg_m),           64'd0);
    check("rst_frame_done", 64'(fd_m),          64'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // idle chain: timing of load, shift clocks and frame period
    wait_fd(0, 2);
    @(negedge clk_sys);
    check("frame_period", 64'(last_period), 64'd233);
    check("load_low",     64'(last_load),   64'd8);
    check("clk_pulses",   64'(last_rises),  64'd24);
    check("clk_high",     64'(last_hi),     64'd96);
    check("idle_joy",     64'(joy_m),       64'd0);
    check("idle_changed", 64'(chg_m_cnt),   64'd0);

    // steady fire on P0 bit4
    wait_fd(0, 1);
    press_m[4] = 1'b1;
    c0 = chg_m_cnt;
    wait_fd(0, 1);
    repeat (2) @(negedge clk_sys);
    check("fire_frame1", 64'(joy_m), 64'd0);
    wait_fd(0, 1);
    repeat (2) @(negedge clk_sys);
    check("fire_joy",      64'(joy_m),      64'h000010);
    check("fire_chg_cnt",  64'(chg_m_cnt),  64'(c0 + 1));
    check("fire_chg_val",  64'(chg_m_last), 64'b01);
    wait_fd(0, 2);
    repeat (2) @(negedge clk_sys);
    check("fire_held_cnt", 64'(chg_m_cnt),  64'(c0 + 1));
    check("fire_held_joy", 64'(joy_m),      64'h000010);

    // one-frame glitch on P1 bit0
    wait_fd(0, 1);
    press_m[12] = 1'b1;
    c0 = chg_m_cnt;
    cb = chg_b_cnt;
    wait_fd(0, 1);
    press_m[12] = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("glitch_db1_joy", 64'(joy_b),      64'h001010);
    check("glitch_db1_chg", 64'(chg_b_last), 64'b10);
    check("glitch_db1_cnt", 64'(chg_b_cnt),  64'(cb + 1));
    wait_fd(0, 2);
    repeat (2) @(negedge clk_sys);
    check("glitch_joy",     64'(joy_m),      64'h000010);
    check("glitch_chg_cnt", 64'(chg_m_cnt),  64'(c0));

    // OSD mask
    wait_fd(0, 1);
    mask = 1'b1;
    @(negedge clk_sys);
    check("mask_on",  64'(joy_m), 64'd0);
    mask = 1'b0;
    @(negedge clk_sys);
    check("mask_off", 64'(joy_m), 64'h000010);
    mask = 1'b1;
    press_m[4] = 1'b0;
    c0 = chg_m_cnt;
    wait_fd(0, 2);
    repeat (2) @(negedge clk_sys);
    check("mask_rel_cnt", 64'(chg_m_cnt),  64'(c0 + 1));
    check("mask_rel_chg", 64'(chg_m_last), 64'b01);
    check("mask_rel_joy", 64'(joy_m),      64'd0);
    mask = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("unmask_joy",   64'(joy_m),      64'd0);

    // enable dropped mid-frame
    press_m[0] = 1'b1;
    wait_fd(0, 2);
    repeat (2) @(negedge clk_sys);
    check("p0b0_joy", 64'(joy_m), 64'h000001);
    wait_rises(10);
    enable = 1'b0;
    wait_fd(0, 1);
    @(negedge clk_sys);
    check("stop_frame_bits", 64'(last_rises), 64'd24);
    repeat (600) @(negedge clk_sys);
    check("stop_load_act", 64'(load_cur), 64'd0);
    check("stop_clk_act",  64'(hi_cur),   64'd0);
    check("stop_joy_hold", 64'(joy_m),    64'h000001);
    enable = 1'b1;
    n = 0;
    while (u_if_m.joy_load && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check("restart_gap", 64'(n >= 29 && n <= 32), 64'd1);

    // reset in the middle of SHIFT
    wait_rises(5);
    reset = 1'b1;
    @(negedge clk_sys);
    check("midrst_joy_clk",  64'(u_if_m.joy_clk),  64'd0);
    check("midrst_joy_load", 64'(u_if_m.joy_load), 64'd1);
    check("midrst_joystick", 64'(joy_m),           64'd0);
    reset = 1'b0;
    wait_fd(2, 1);
    repeat (2) @(negedge clk_sys);
    check("wide_frame1", joy_c, 64'd0);
    wait_fd(2, 1);
    repeat (2) @(negedge clk_sys);
    check("wide_p3b15", joy_c, 64'h8000_0000_0000_0000);
    check("after_rst_joy", 64'(joy_m), 64'h000001);
    check("no_overlap", 64'(overlap), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
